// File: rtl/fir_3_parallel_ffa_prog.sv
// fir_3_parallel_ffa_prog: 3-parallel fast-FIR (FFA) filter with programmable
// coefficients. Each cycle it takes one block of three samples (x(3k), x(3k+1),
// x(3k+2)) and produces the matching three outputs one clock later. Six
// N-tap sub-filters (N = ceil(TAPS/3)) run on H0, H1, H2, H0+H1, H1+H2 and
// H0+H1+H2.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         input block handshake
//   in_x0 / in_x1 / in_x2       x(3k), x(3k+1), x(3k+2)
//   out_valid                   one-cycle pulse per accepted block
//   out_y0 / out_y1 / out_y2    y(3k), y(3k+1), y(3k+2)
//   coef_wr/coef_addr/coef_data write tap h[coef_addr] into the shadow bank
//   coef_commit                 copy shadow into the active bank and flush state
//   sat_o                       output block was clamped (saturating build only)
//
// Build option: define FIR3P_SAT_EN to clamp outputs to OUT_W. When it is not
// defined, outputs are the low OUT_W bits of the result and sat_o is 0.

// One transposed-form sub-filter. y_o is combinational for the current sample.
module fir3p_subfilt #(
  parameter int N     = 57,
  parameter int CW    = 16,
  parameter int XW    = 16,
  parameter int ACC_W = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [N-1:0][CW-1:0]     coef_i,
  input  logic signed [XW-1:0]     x_i,
  output logic signed [ACC_W-1:0]  y_o
);
  logic [N-1:0][ACC_W-1:0] p;
  logic [N-1:0][ACC_W-1:0] z_q, z_d;

  // The last delay stage has nothing feeding it; it stays zero so the chain
  // is uniform for any N.
  always_comb begin
    z_d = '0;
    for (int i = 0; i < N; i++)
      p[i] = ACC_W'($signed(coef_i[i])) * ACC_W'(x_i);
    for (int i = 0; i < N-1; i++)
      z_d[i] = p[i+1] + z_q[i+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     z_q <= '0;
    else if (clr_i) z_q <= '0;
    else if (en_i)  z_q <= z_d;
  end

  assign y_o = p[0] + z_q[0];
endmodule

module fir_3_parallel_ffa_prog #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 170,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_x0,
  input  logic signed [DATA_W-1:0]  in_x1,
  input  logic signed [DATA_W-1:0]  in_x2,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_y0,
  output logic signed [OUT_W-1:0]   out_y1,
  output logic signed [OUT_W-1:0]   out_y2,
  input  logic                      coef_wr,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      coef_commit,
  output logic                      sat_o
);
  localparam int N  = (TAPS + 2) / 3;
  localparam int GW = COEF_W + 2;

  typedef enum logic [1:0] {RUN, COMMIT, CLEAR} state_e;
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (coef_commit) state_d = COMMIT;
      COMMIT:  state_d = CLEAR;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  logic acc, clr, load;
  assign in_ready = (state_q == RUN);
  assign acc      = in_valid && in_ready;
  assign clr      = (state_q == CLEAR);
  assign load     = (state_q == COMMIT);

  // Shadow bank padded to 3*N entries; the pad entries are never written and
  // read as zero taps.
  logic [3*N-1:0][COEF_W-1:0] shadow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else if (coef_wr && (32'(coef_addr) < TAPS)) shadow_q[coef_addr] <= coef_data;
  end

  // Polyphase split and the summed banks, all captured in the COMMIT cycle
  // from the pre-write shadow contents.
  logic [N-1:0][COEF_W-1:0] h0_q, h1_q, h2_q;
  logic [N-1:0][GW-1:0]     g01_q, g12_q, g012_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q <= '0; h1_q <= '0; h2_q <= '0;
      g01_q <= '0; g12_q <= '0; g012_q <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        h0_q[i]   <= shadow_q[3*i];
        h1_q[i]   <= shadow_q[3*i+1];
        h2_q[i]   <= shadow_q[3*i+2];
        g01_q[i]  <= GW'($signed(shadow_q[3*i]))   + GW'($signed(shadow_q[3*i+1]));
        g12_q[i]  <= GW'($signed(shadow_q[3*i+1])) + GW'($signed(shadow_q[3*i+2]));
        g012_q[i] <= GW'($signed(shadow_q[3*i]))   + GW'($signed(shadow_q[3*i+1]))
                   + GW'($signed(shadow_q[3*i+2]));
      end
    end
  end

  // Sign-extended pre-adders
  logic signed [DATA_W:0]   s01, s12;
  logic signed [DATA_W+1:0] s012;
  assign s01  = (DATA_W+1)'(in_x0) + (DATA_W+1)'(in_x1);
  assign s12  = (DATA_W+1)'(in_x1) + (DATA_W+1)'(in_x2);
  assign s012 = (DATA_W+2)'(in_x0) + (DATA_W+2)'(in_x1) + (DATA_W+2)'(in_x2);

  logic signed [ACC_W-1:0] p_y, q_y, r_y, s_y, t_y, u_y;

  fir3p_subfilt #(.N(N), .CW(COEF_W), .XW(DATA_W),   .ACC_W(ACC_W)) u_h0 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(h0_q),   .x_i(in_x0), .y_o(p_y));
  fir3p_subfilt #(.N(N), .CW(COEF_W), .XW(DATA_W),   .ACC_W(ACC_W)) u_h1 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(h1_q),   .x_i(in_x1), .y_o(q_y));
  fir3p_subfilt #(.N(N), .CW(COEF_W), .XW(DATA_W),   .ACC_W(ACC_W)) u_h2 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(h2_q),   .x_i(in_x2), .y_o(r_y));
  fir3p_subfilt #(.N(N), .CW(GW),     .XW(DATA_W+1), .ACC_W(ACC_W)) u_g01 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(g01_q),  .x_i(s01),   .y_o(s_y));
  fir3p_subfilt #(.N(N), .CW(GW),     .XW(DATA_W+1), .ACC_W(ACC_W)) u_g12 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(g12_q),  .x_i(s12),   .y_o(t_y));
  fir3p_subfilt #(.N(N), .CW(GW),     .XW(DATA_W+2), .ACC_W(ACC_W)) u_g012 (
    .clk, .rst_n, .en_i(acc), .clr_i(clr), .coef_i(g012_q), .x_i(s012),  .y_o(u_y));

  // FFA post-processing; dr_q/de_q are the one-block delays of R and E.
  logic signed [ACC_W-1:0] a_y, b_y, e_y, y0, y1, y2, dr_q, de_q;
  assign a_y = p_y - dr_q;
  assign b_y = s_y - q_y;
  assign e_y = t_y - q_y;
  assign y0  = a_y + de_q;
  assign y1  = b_y - a_y;
  assign y2  = u_y - b_y - e_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     begin dr_q <= '0;  de_q <= '0;  end
    else if (clr)   begin dr_q <= '0;  de_q <= '0;  end
    else if (acc)   begin dr_q <= r_y; de_q <= e_y; end
  end

  logic [OUT_W-1:0] y0_d, y1_d, y2_d, y0_q, y1_q, y2_q;
  logic             vld_q;

`ifdef FIR3P_SAT_EN
  // Returns {clamped, value}. In range when the low OUT_W bits sign-extend
  // back to the full value.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (ACC_W'($signed(v[OUT_W-1:0])) == v) return {1'b0, v[OUT_W-1:0]};
    else if (v[ACC_W-1])                    return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else                                    return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  logic [OUT_W:0] r0, r1, r2;
  logic           sat_d, sat_q;
  always_comb begin
    r0    = sat_fn(y0);
    r1    = sat_fn(y1);
    r2    = sat_fn(y2);
    y0_d  = r0[OUT_W-1:0];
    y1_d  = r1[OUT_W-1:0];
    y2_d  = r2[OUT_W-1:0];
    sat_d = r0[OUT_W] | r1[OUT_W] | r2[OUT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= acc && sat_d;
  end
  assign sat_o = sat_q;
`else
  always_comb begin
    y0_d = OUT_W'(y0);
    y1_d = OUT_W'(y1);
    y2_d = OUT_W'(y2);
  end
  assign sat_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      y0_q <= '0; y1_q <= '0; y2_q <= '0;
    end else begin
      vld_q <= acc;
      if (acc) begin
        y0_q <= y0_d; y1_q <= y1_d; y2_q <= y2_d;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_y0    = y0_q;
  assign out_y1    = y1_q;
  assign out_y2    = y2_q;
endmodule

// File: tb/tb_fir_3_parallel_ffa_prog.sv
// Scoreboard bench for fir_3_parallel_ffa_prog: expected blocks come from a
// direct-form convolution model and are queued on accept, then popped when
// out_valid is seen.
module tb_fir_3_parallel_ffa_prog;
  localparam int DATA_W = 16, COEF_W = 16, TAPS = 170, ACC_W = 40, OUT_W = 20;
  localparam int AW = $clog2(TAPS);
  localparam longint MAXV = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (OUT_W-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, out_valid, coef_wr, coef_commit, sat_o;
  logic signed [DATA_W-1:0] in_x0, in_x1, in_x2;
  logic [OUT_W-1:0] out_y0, out_y1, out_y2;
  logic [AW-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;

  fir_3_parallel_ffa_prog #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
                            .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .out_valid(out_valid),
    .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .sat_o(sat_o));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [OUT_W-1:0] y0, y1, y2;
    logic             s;
  } exp_t;

  int   h_sh [TAPS];
  int   h_act[TAPS];
  int   xs[$];
  exp_t q[$];
  exp_t last;
  bit   acc_last;

  function automatic void conv(input int n, output logic [OUT_W-1:0] y, output logic s);
    longint acc = 0;
    logic signed [ACC_W-1:0] a;
`ifdef FIR3P_SAT_EN
    longint v;
`endif
    for (int m = 0; m < TAPS && m <= n; m++)
      acc += longint'(h_act[m]) * longint'(xs[n-m]);
    a = acc[ACC_W-1:0];
`ifdef FIR3P_SAT_EN
    v = a;
    s = 1'b0;
    if (v > MAXV)      begin v = MAXV; s = 1'b1; end
    else if (v < MINV) begin v = MINV; s = 1'b1; end
    y = v[OUT_W-1:0];
`else
    s = 1'b0;
    y = a[OUT_W-1:0];
`endif
  endfunction

  function automatic void model_accept(input int x0, input int x1, input int x2);
    exp_t e;
    logic s0, s1, s2;
    int n;
    xs.push_back(x0); xs.push_back(x1); xs.push_back(x2);
    n = xs.size() - 3;
    conv(n,   e.y0, s0);
    conv(n+1, e.y1, s1);
    conv(n+2, e.y2, s2);
    e.s = s0 | s1 | s2;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin h_sh[i] = 0; h_act[i] = 0; end
    xs.delete();
    q.delete();
    last = '0;
    acc_last = 1'b0;
  endfunction

  // Output monitor: every cycle, valid must follow the previous accept and
  // outputs must either match the scoreboard or hold.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", out_valid, acc_last);
    if (out_valid) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = q.pop_front();
        chk("y0", out_y0, e.y0);
        chk("y1", out_y1, e.y1);
        chk("y2", out_y2, e.y2);
        chk("sat", sat_o, e.s);
        last = e;
      end
    end else begin
      chk("hold_y0", out_y0, last.y0);
      chk("hold_y1", out_y1, last.y1);
      chk("hold_y2", out_y2, last.y2);
      chk("sat_idle", sat_o, 0);
    end
  end

  // One clock: drive, decide accept before the edge, advance past the edge.
  task automatic step(input bit v, input int x0, input int x1, input int x2);
    bit acc;
    in_valid = v;
    in_x0 = DATA_W'(x0); in_x1 = DATA_W'(x1); in_x2 = DATA_W'(x2);
    @(negedge clk);
    acc = v && in_ready;
    if (acc) model_accept(x0, x1, x2);
    if (coef_wr && int'(coef_addr) < TAPS) h_sh[coef_addr] = int'(coef_data);
    @(posedge clk); #1;
    acc_last = acc;
    in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0;
  endtask

  task automatic prog(input int idx, input int val);
    coef_wr = 1'b1; coef_addr = AW'(idx); coef_data = COEF_W'(val);
    step(0, 0, 0, 0);
  endtask

  task automatic commit(input bit v, input int x, input bit wr_mid, input bit rst_mid);
    coef_commit = 1'b1;
    step(v, x, x, x);
    chk("rdy_commit", in_ready, 0);
    for (int i = 0; i < TAPS; i++) h_act[i] = h_sh[i];
    xs.delete();
    if (rst_mid) begin
      rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      return;
    end
    if (wr_mid) begin coef_wr = 1'b1; coef_addr = AW'(1); coef_data = 16'sd9; end
    coef_commit = 1'b1;
    step(1, 7, 7, 7);
    chk("rdy_clear", in_ready, 0);
    coef_commit = 1'b1;
    step(1, 7, 7, 7);
    chk("rdy_back", in_ready, 1);
  endtask

  task automatic impulse(input int zeros);
    step(1, 1, 0, 0);
    repeat (zeros) step(1, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0;
    in_x0 = '0; in_x1 = '0; in_x2 = '0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rdy", in_ready, 1);

    // Impulse through h[n] = n+1
    for (int n = 0; n < TAPS; n++) prog(n, n + 1);
    commit(0, 0, 0, 0);
    impulse(58);
    repeat (2) step(0, 0, 0, 0);

    // Same impulse with valid gaps 1,0,0,1
    for (int k = 0; k < 59; k++) begin
      step(1, (k == 0) ? 1 : 0, 0, 0);
      step(0, 5, 5, 5);
      step(0, 5, 5, 5);
    end

    // DC settle, then commit flushes history
    for (int n = 0; n < TAPS; n++) prog(n, 1);
    commit(0, 0, 0, 0);
    repeat (60) step(1, 100, 100, 100);
    chk("dc_settle_y0", out_y0, 17000);
    chk("dc_settle_y2", out_y2, 17000);
    commit(1, 100, 1, 0);
    step(1, 100, 100, 100);
    chk("restart_y0", out_y0, 100);
    chk("restart_y1", out_y1, 200);
    chk("restart_y2", out_y2, 300);
    repeat (3) step(1, 100, 100, 100);

    // Shadow isolation and out-of-range write
    coef_wr = 1'b1; coef_addr = AW'(0); coef_data = 16'sd5;
    step(1, 100, 100, 100);
    coef_wr = 1'b1; coef_addr = AW'(200); coef_data = 16'sd7;
    step(1, 100, 100, 100);
    repeat (4) step(1, 100, 100, 100);
    commit(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("shadow_y0", out_y0, 5);
    repeat (58) step(1, 0, 0, 0);

    // Random coefficients written while streaming, random gaps
    for (int n = 0; n < TAPS; n++) begin
      coef_wr = 1'b1; coef_addr = AW'(n);
      coef_data = COEF_W'(int'($urandom_range(4000)) - 2000);
      step(bit'($urandom_range(1)), int'($urandom_range(60000)) - 30000,
           int'($urandom_range(60000)) - 30000, int'($urandom_range(60000)) - 30000);
    end
    commit(0, 0, 0, 0);
    repeat (80)
      step(bit'($urandom_range(1)), int'($urandom_range(600)) - 300,
           int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300);

    // Reset during COMMIT discards everything
    commit(0, 0, 0, 1);
    chk("rst_mid_rdy", in_ready, 1);
    impulse(58);

    // Saturation / wrap corner
    prog(0, 32767);
    commit(0, 0, 0, 0);
    step(1, 32767, 32767, 32767);
`ifdef FIR3P_SAT_EN
    chk("sat_y0", out_y0, 20'd524287);
    chk("sat_flag", sat_o, 1);
`else
    chk("wrap_y0", out_y0, 20'd983041);
    chk("sat_flag", sat_o, 0);
`endif
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_3_parallel_ffa_prog.md
Name: fir_3_parallel_ffa_prog

Overview:
Parametrised 3-parallel fast-FIR (FFA) filter with six sub-filters (H0, H1, H2, H0+H1, H1+H2, H0+H1+H2).
- Processes 3 samples per clock under a valid/ready handshake.
- Coefficients are runtime-programmable through a shadow bank, with a commit sequence that also flushes filter state.
- Sits after the decimating front end. Replaces fixed-coefficient parallel filters in the DSP datapath.

Parameters:
- DATA_W, 16: input sample width, signed.
- COEF_W, 16: coefficient width, signed.
- TAPS, 170: full filter length. Sub-filter length N = ceil(TAPS/3). Coefficients at index ≥ TAPS are zero.
- ACC_W, 40: internal accumulator width, signed. All sub-filter outputs and FFA adds use ACC_W.
- OUT_W, 40: output width, OUT_W ≤ ACC_W.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: the in_x0/in_x1/in_x2 block is valid.
- in_ready, out, 1: block accepted when in_valid && in_ready.
- in_x0, in, DATA_W: x(3k), signed.
- in_x1, in, DATA_W: x(3k+1), signed.
- in_x2, in, DATA_W: x(3k+2), signed.
- out_valid, out, 1: output block valid, one-cycle pulse per accepted block.
- out_y0, out, OUT_W: y(3k), signed.
- out_y1, out, OUT_W: y(3k+1), signed.
- out_y2, out, OUT_W: y(3k+2), signed.
- coef_wr, in, 1: write the shadow coefficient bank.
- coef_addr, in, $clog2(TAPS): tap index n. Writes with n ≥ TAPS are ignored.
- coef_data, in, COEF_W: h[n], signed.
- coef_commit, in, 1: one-cycle request to activate the shadow bank.
- sat_o, out, 1: the current output block saturated. Meaningful only with the optional feature.

Behaviour:
- Reset (rst_n=0, async):
  - Shadow and active banks = 0.
  - All sub-filter delay registers and block-delay registers = 0.
  - out_valid=0, out_y*=0, sat_o=0.
  - FSM = RUN, in_ready=1 on the first cycle after reset release.
  - Reset mid-operation discards all state, including a pending commit.
- Shadow bank: coef_wr writes shadow[coef_addr] in any state. It never affects the active filter until commit.
- FSM states RUN, COMMIT, CLEAR:
  - RUN: in_ready=1. coef_commit=1 moves to COMMIT. A block accepted in the same cycle as coef_commit is processed with the old coefficients.
  - COMMIT (1 cycle):
    - active ← shadow.
    - Registered derived banks: G01[i]=H0[i]+H1[i], G12[i]=H1[i]+H2[i], G012[i]=H0[i]+H1[i]+H2[i], each COEF_W+2 bits.
    - Hj[i] = h[3i+j].
    - in_ready=0.
  - CLEAR (1 cycle): zero all delay and block-delay registers. in_ready=0. Then → RUN.
  - coef_commit outside RUN is ignored.
  - A coef_wr in the COMMIT cycle is written to shadow but not copied (copy uses the pre-write value).
- Sub-filters:
  - Transposed form, N taps each.
  - Register enable = accepted block only. State holds when in_valid=0.
  - Pre-adders are sign-extended: x0+x1 and x1+x2 at DATA_W+1 bits, x0+x1+x2 at DATA_W+2 bits.
- FFA post-processing, where D = one accepted-block delay (register enabled by accept):
  - P = H0x0, Q = H1x1, R = H2x2, S = G01(x0+x1), T = G12(x1+x2), U = G012(x0+x1+x2).
  - A = P − D(R).
  - B = S − Q.
  - E = T − Q.
  - y0 = A + D(E).
  - y1 = B − A.
  - y2 = U − B − E.
- Output timing:
  - Outputs registered. out_valid=1 exactly one cycle after each accept, otherwise 0.
  - out_y* hold their last value while out_valid=0.
  - Latency is 1 clock regardless of in_valid gaps.
- Result: output equals the direct-form convolution y(n)=Σ h[m]x(n−m), computed at ACC_W.
- Width rule: ACC_W wraps (two's complement). Final OUT_W conversion is per the optional feature.

Optional Feature:
- Macro FIR3P_SAT_EN.
- Defined: each y clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. sat_o=1 in the out_valid cycle if any lane clamped, else 0.
- Undefined: out_y* = low OUT_W bits of the ACC_W result. sat_o tied to 0.

Test Plan:
- Impulse, TAPS=170, h[n]=n+1 committed, then blocks (1,0,0) followed by zeros → out blocks (1,2,3), (4,5,6), …, (169,170,0), then (0,0,0). out_valid one cycle after each accept.
- Handshake gaps: same impulse with in_valid toggling 1,0,0,1 → identical output sequence. out_valid only after accepts. Outputs held between blocks.
- Commit: stream a DC of 100 with h[n]=1, which settles to 17000 per lane. Pulse coef_commit → in_ready=0 for exactly 2 cycles. First post-commit outputs restart from zero history: block0 = (100, 200, 300).
- Shadow isolation: write shadow h[0]=5 without commit while streaming → outputs unchanged. After commit, impulse gives y(0)=5.
- Reset mid-stream: assert rst_n=0 during COMMIT → out_valid=0, in_ready=1 after release, and an impulse gives all-zero outputs (active bank = 0).
- Saturation, OUT_W=20, h[0]=32767, x=32767:
  - FIR3P_SAT_EN defined → y=524287, sat_o=1.
  - Undefined → out_y0 = low 20 bits of 1073676289, sat_o=0.
